// File: rtl/dec_digit_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dec_digit_serializer: binary value -> decimal digits, MSD first, no      |
// | leading zeros. Revision 1.0                                              |
// +--------------------------------------------------------------------------+

module division_flash #(
    parameter int BIT_DEPTH = 32
) (
    input  logic [BIT_DEPTH-1:0] dividend,
    input  logic [BIT_DEPTH-1:0] divisor,
    output logic [BIT_DEPTH-1:0] quotient,
    output logic [BIT_DEPTH-1:0] remainder
);
    always_comb begin
        quotient  = '1;
        remainder = dividend;
        if (divisor != '0) begin
            quotient  = dividend / divisor;
            remainder = dividend % divisor;
        end
    end
endmodule

module dec_digit_serializer #(
    parameter int BIT_DEPTH = 32,
    parameter int DIGITS    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_DEPTH-1:0] in_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_digit,
    output logic                 out_last,
    output logic                 busy
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [BIT_DEPTH-1:0] C_TEN = BIT_DEPTH'(10);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BIT_DEPTH-1:0] work_q, work_d;
    logic [3:0]           dig_q [DIGITS];
    logic [3:0]           dig_d [DIGITS];
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        idx_q, idx_d;

    logic [BIT_DEPTH-1:0] w_quo;
    logic [BIT_DEPTH-1:0] w_rem;
    logic [BIT_DEPTH-5:0] w_rem_hi_unused;

    division_flash #(
        .BIT_DEPTH (BIT_DEPTH)
    ) u_div (
        .dividend  (work_q),
        .divisor   (C_TEN),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Remainder of a divide-by-ten never exceeds 9, so only the nibble matters.
    assign w_rem_hi_unused = w_rem[BIT_DEPTH-1:4];

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = in_value;
                    cnt_d   = '0;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                dig_d[cnt_q] = w_rem[3:0];
                cnt_d        = cnt_q + 1'b1;
                work_d       = w_quo;
                if (w_quo == '0) begin
                    idx_d   = cnt_q;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                dig_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_EMIT);
    assign out_digit = out_valid ? dig_q[idx_q] : 4'd0;
    assign out_last  = out_valid && (idx_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_dec_digit_serializer.sv
`default_nettype none
// Bench for dec_digit_serializer: table of values plus hand-written corner
// sequences; expected digits go into a scoreboard queue checked at handshake.

module tb_dec_digit_serializer;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_digit;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] d;
        logic       l;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] value;
        int          n;
    } vec_t;
    vec_t tbl[6];

    dec_digit_serializer #(
        .BIT_DEPTH (32),
        .DIGITS    (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_digit: got %0d with no digit expected at %0t",
                         out_digit, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("digit", 32'(out_digit), 32'(e.d));
                chk("last", 32'(out_last), 32'(e.l));
            end
        end
    end

    task automatic push_digits(input logic [31:0] v);
        logic [3:0]  ds[10];
        logic [31:0] t;
        int          k;
        exp_t        e;
        t = v;
        k = 0;
        do begin
            ds[k] = 4'(t % 10);
            k++;
            t = t / 10;
        end while (t != 0);
        for (int i = k - 1; i >= 0; i--) begin
            e.d = ds[i];
            e.l = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    // Returns at posedge+1 of the first cycle with out_valid high.
    task automatic send(input logic [31:0] v, input int n);
        int lat;
        wait_idle();
        push_digits(v);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = $urandom;
        @(negedge clk);
        chk("ready_after_accept", 32'(in_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk("latency", 32'(lat), 32'(n));
    endtask

    task automatic drain(input int exp_cycles);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        if (exp_cycles >= 0) begin
            chk("emit_cycles", 32'(cyc), 32'(exp_cycles));
            chk("ready_after_last", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'd1234, 4};
        tbl[1] = '{32'd0, 1};
        tbl[2] = '{32'd9, 1};
        tbl[3] = '{32'd10, 2};
        tbl[4] = '{32'd4294967295, 10};
        tbl[5] = '{32'd70, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_digit", 32'(out_digit), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b1;
            send(tbl[i].value, tbl[i].n);
            drain(tbl[i].n);
        end

        // Backpressure: three stalled cycles per digit
        out_ready = 1'b0;
        send(32'd65535, 5);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] d0;
            logic       l0;
            d0 = out_digit;
            l0 = out_last;
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_digit", 32'(out_digit), 32'(d0));
                chk("stall_last", 32'(out_last), 32'(l0));
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        chk("bp_drained", 32'(sb.size()), 32'd0);
        chk("bp_ready_after_last", 32'(in_ready), 32'd1);
        sb.delete();

        // Reset in the middle of EMIT
        out_ready = 1'b1;
        send(32'd257, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_digit", 32'(out_digit), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        sb.delete();
        in_valid = 1'b1;
        in_value = 32'd999;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ignores_accept", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        send(32'd100, 3);
        drain(3);

        // Back-to-back with in_valid held high
        wait_idle();
        out_ready = 1'b1;
        push_digits(32'd56);
        push_digits(32'd100);
        in_valid = 1'b1;
        in_value = 32'd56;
        @(posedge clk);
        #1;
        in_value = 32'd100;
        begin
            int g;
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!(out_valid && out_last) && g < 50);
            chk("b2b_first_last_seen", 32'(out_valid && out_last), 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready_gap", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_accept", 32'(busy), 32'd1);
        chk("b2b_second_not_ready", 32'(in_ready), 32'd0);
        drain(-1);
        @(posedge clk);
        #1;
        chk("b2b_final_idle", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dec_digit_serializer.md
# dec_digit_serializer

Sequential binary-to-decimal stage placed directly downstream of `division_flash`. It accepts one unsigned `BIT_DEPTH`-bit value over a valid/ready handshake and feeds it repeatedly through one internal `division_flash` instance with a constant divisor of 10. Each remainder is captured as a decimal digit. The digits are then streamed out most-significant first, one per handshake, with leading zeros suppressed. Its consumer is a display or character-output path.

## Interface
- `BIT_DEPTH`, 32, width of the input value; passed unchanged to the internal `division_flash`.
- `DIGITS`, 10, depth of the digit buffer; must be ≥ the decimal digit count of 2^BIT_DEPTH−1 (10 for 32 bits).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_value` is offered.
- `in_ready`  out  1  block can accept a value; high exactly in state IDLE.
- `in_value`  in  BIT_DEPTH  unsigned value to convert.
- `out_valid`  out  1  `out_digit` is valid; high exactly in state EMIT.
- `out_ready`  in  1  consumer takes the digit.
- `out_digit`  out  4  decimal digit 0–9, binary coded.
- `out_last`  out  1  current digit is the least significant one of this value.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Internal registers:
  - `work` (BIT_DEPTH)
  - digit buffer `buf[DIGITS]` (4 bits each)
  - `cnt` (digits captured)
  - `idx` (emit pointer)
  - `state`
- `division_flash` instance: `dividend`=`work`, `divisor`=10. Only the low 4 bits of `remainder` are stored; the upper bits are always 0.
- **IDLE**: `in_ready`=1. On `in_valid & in_ready`: `work`←`in_value`, `cnt`←0, go to DIVIDE.
- **DIVIDE**: one division per cycle.
  - `buf[cnt]`←remainder, `cnt`←`cnt`+1, `work`←quotient.
  - If quotient == 0: `idx`←`cnt` (the index of the digit just written), go to EMIT.
  - Input 0 therefore produces exactly one digit, "0". No other leading zeros are ever produced.
- **EMIT**: `out_valid`=1, `out_digit`=`buf[idx]`, `out_last`=(`idx`==0).
  - On `out_valid & out_ready`: if `idx`==0 go to IDLE, else `idx`←`idx`−1.
  - Without `out_ready`, `out_digit` and `out_last` hold stable.
- No abort path. Once accepted, a value is always fully emitted unless reset intervenes.
- `in_value` is sampled only at the accept edge. Later changes to it have no effect.

## Timing
- Reset (`rst_n` low, asynchronous, any state):
  - state←IDLE, `cnt`,`idx`,`work`←0.
  - `out_valid`=0, `out_last`=0, `out_digit`=0, `busy`=0, `in_ready`=1.
  - Any handshake while `rst_n` is low is ignored.
  - Reset mid-DIVIDE or mid-EMIT discards the value; no further digits appear.
- For a value with N decimal digits (N ≥ 1):
  - Accept at edge 0.
  - DIVIDE occupies edges 1..N.
  - `out_valid` is high in the cycle after edge N.
  - Minimum total occupancy is 2N+1 cycles, including the accept cycle.
- Final digit handshake at edge k returns the block to IDLE, so `in_ready`=1 after edge k. The next value is accepted at edge k+1 at the earliest; there is no same-edge accept.
- All outputs are registered or decoded from registers only. There is no combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.

## Test plan
- **1234**, `out_ready`=1: `in_ready` drops after accept; `out_valid` rises 4 cycles after the accept edge; digits 1,2,3,4 on consecutive cycles; `out_last` only on 4; `in_ready`=1 on the next cycle.
- **0**: a single digit 0 with `out_last`=1. **9**: a single 9. **10**: digits 1,0.
- **4294967295** (BIT_DEPTH=32): 10 DIVIDE cycles, then digits 4,2,9,4,9,6,7,2,9,5; `out_last` on the final 5.
- **Backpressure**, 65535: hold `out_ready`=0 for 3 cycles at each digit; `out_digit` and `out_last` stable while stalled; sequence 6,5,5,3,5 unchanged. `in_value` changed mid-conversion has no effect.
- **Reset mid-EMIT**, 257: assert `rst_n` low after digit 2 is handshaken. Outputs clear immediately, asynchronously, to the reset values. After release, 100 converts cleanly to 1,0,0.
- **Back-to-back**, `in_valid` held high with 56 then 100: 56 is accepted first; 100 is accepted on the edge after the handshake of 6. The output stream is 5,6(last),1,0,0(last) with no interleaving.
